io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_pkg.sv | 25 ++
 rtl/sync2.sv | 24 ++
 rtl/io_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the external IO bus arbiter.
package io_bus_pkg;

  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 16;
  localparam int IO_BE_W   = 2;

  localparam logic [IO_DATA_W-1:0] TIMEOUT_RDATA = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMPLETE
  } state_e;

  // Round-robin pick: a lone requester always wins; on a tie the master
  // that did not win last time goes first.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter and single-transaction sequencer for the
// 16-bit external IO bus, with acknowledge timeout and irq synchronisation.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 m0_req,
  input  logic                 m0_rw,
  input  logic [IO_ADDR_W-1:0] m0_address,
  input  logic [IO_BE_W-1:0]   m0_byte_enable,
  input  logic [IO_DATA_W-1:0] m0_write_data,
  output logic                 m0_done,
  output logic                 m0_timeout,
  output logic [IO_DATA_W-1:0] m0_read_data,

  input  logic                 m1_req,
  input  logic                 m1_rw,
  input  logic [IO_ADDR_W-1:0] m1_address,
  input  logic [IO_BE_W-1:0]   m1_byte_enable,
  input  logic [IO_DATA_W-1:0] m1_write_data,
  output logic                 m1_done,
  output logic                 m1_timeout,
  output logic [IO_DATA_W-1:0] m1_read_data,

  output logic [IO_ADDR_W-1:0] io_address,
  output logic                 io_bus_enable,
  output logic [IO_BE_W-1:0]   io_byte_enable,
  output logic                 io_rw,
  output logic [IO_DATA_W-1:0] io_write_data,
  input  logic [IO_DATA_W-1:0] io_read_data,
  input  logic                 io_acknowledge,
  input  logic                 io_irq,

  output logic                 irq_sync,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            last_q, last_d;
  logic                            grant_q, grant_d;
  logic                            win;

  logic [IO_ADDR_W-1:0]            io_addr_q, io_addr_d;
  logic [IO_BE_W-1:0]              io_be_q, io_be_d;
  logic                            io_rw_q, io_rw_d;
  logic [IO_DATA_W-1:0]            io_wdata_q, io_wdata_d;
  logic                            bus_en_q, bus_en_d;
  logic                            busy_q, busy_d;

  logic [1:0]                      done_q, done_d;
  logic [1:0]                      timeout_q, timeout_d;
  logic [1:0][IO_DATA_W-1:0]       rdata_q, rdata_d;

  always_comb begin
    // NOTE: every signal gets its hold value before the case statement so no
    // path through the logic leaves one unassigned (which would infer a latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    io_addr_d  = io_addr_q;
    io_be_d    = io_be_q;
    io_rw_d    = io_rw_q;
    io_wdata_d = io_wdata_q;
    rdata_d    = rdata_q;
    done_d     = 2'b00;
    timeout_d  = 2'b00;
    win        = rr_pick(m0_req, m1_req, last_q);

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d    = win;
          last_d     = win;
          io_rw_d    = win ? m1_rw          : m0_rw;
          io_addr_d  = win ? m1_address     : m0_address;
          io_be_d    = win ? m1_byte_enable : m0_byte_enable;
          io_wdata_d = win ? m1_write_data  : m0_write_data;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Acknowledge takes priority over a timeout landing in the same cycle.
        if (io_acknowledge) begin
          state_d          = COMPLETE;
          done_d[grant_q]  = 1'b1;
          if (io_rw_q) begin
            rdata_d[grant_q] = io_read_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d            = COMPLETE;
          done_d[grant_q]    = 1'b1;
          timeout_d[grant_q] = 1'b1;
          if (io_rw_q) begin
            rdata_d[grant_q] = TIMEOUT_RDATA;
          end
        end
      end

      COMPLETE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    bus_en_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      grant_q    <= 1'b0;
      io_addr_q  <= '0;
      io_be_q    <= '0;
      io_rw_q    <= 1'b1;
      io_wdata_q <= '0;
      bus_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 2'b00;
      timeout_q  <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      io_addr_q  <= io_addr_d;
      io_be_q    <= io_be_d;
      io_rw_q    <= io_rw_d;
      io_wdata_q <= io_wdata_d;
      bus_en_q   <= bus_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
    end
  end

  sync2 u_irq_sync (
    .clk (clk),
    .rst (reset),
    .d   (io_irq),
    .q   (irq_sync)
  );

  assign io_address     = io_addr_q;
  assign io_byte_enable = io_be_q;
  assign io_rw          = io_rw_q;
  assign io_write_data  = io_wdata_q;
  assign io_bus_enable  = bus_en_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;

  assign m0_done        = done_q[0];
  assign m1_done        = done_q[1];
  assign m0_timeout     = timeout_q[0];
  assign m1_timeout     = timeout_q[1];
  assign m0_read_data   = rdata_q[0];
  assign m1_read_data   = rdata_q[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: vector table, directed corner
// sequences and randomized transactions against a transaction-level model.
module tb_io_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [15:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [1:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_done, m0_timeout, m1_done, m1_timeout;
  logic [15:0] m0_read_data, m1_read_data;
  logic [15:0] io_address, io_write_data, io_read_data;
  logic [1:0]  io_byte_enable;
  logic        io_bus_enable, io_rw, io_acknowledge, io_irq;
  logic        irq_sync, busy, grant_id;

  always #5 clk = ~clk;

  io_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req         (m0_req),
    .m0_rw          (m0_rw),
    .m0_address     (m0_address),
    .m0_byte_enable (m0_byte_enable),
    .m0_write_data  (m0_write_data),
    .m0_done        (m0_done),
    .m0_timeout     (m0_timeout),
    .m0_read_data   (m0_read_data),
    .m1_req         (m1_req),
    .m1_rw          (m1_rw),
    .m1_address     (m1_address),
    .m1_byte_enable (m1_byte_enable),
    .m1_write_data  (m1_write_data),
    .m1_done        (m1_done),
    .m1_timeout     (m1_timeout),
    .m1_read_data   (m1_read_data),
    .io_address     (io_address),
    .io_bus_enable  (io_bus_enable),
    .io_byte_enable (io_byte_enable),
    .io_rw          (io_rw),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .io_acknowledge (io_acknowledge),
    .io_irq         (io_irq),
    .irq_sync       (irq_sync),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } fields_t;

  typedef struct {
    logic        r0;
    logic        r1;
    fields_t     f0;
    fields_t     f1;
    int          ack_at;     // ISSUE cycle (1-based) carrying the ack; 0 = never
    logic [15:0] dev;
    bit          keep;       // leave requests high for the next transaction
    logic        exp_grant;
    logic        exp_to;
    logic [15:0] exp_rd;
    int          exp_cycles;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          last_owner;
  logic [15:0] shadow [2];
  vec_t        tbl [11];
  vec_t        rv;
  fields_t     rf;
  logic [1:0]  pick;
  bit          acked;
  int          first_hi, hi_cnt;
  logic        seen_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic r1, input fields_t f0, input fields_t f1,
                              input int ack_at, input logic [15:0] dev, input bit keep,
                              input logic g, input logic to, input logic [15:0] rd, input int cyc);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.f0 = f0; v.f1 = f1;
    v.ack_at = ack_at; v.dev = dev; v.keep = keep;
    v.exp_grant = g; v.exp_to = to; v.exp_rd = rd; v.exp_cycles = cyc;
    return v;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    m0_req = 0; m1_req = 0; io_acknowledge = 0; io_irq = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_owner = 1;
    shadow[0] = 16'h0;
    shadow[1] = 16'h0;
  endtask

  // Starts in an IDLE cycle at a negedge, returns at the negedge of the IDLE
  // cycle that follows COMPLETE.
  task automatic run_txn(input vec_t v);
    fields_t fw;
    int      n;
    m0_req = v.r0; m0_rw = v.f0.rw; m0_address = v.f0.addr;
    m0_byte_enable = v.f0.be; m0_write_data = v.f0.wd;
    m1_req = v.r1; m1_rw = v.f1.rw; m1_address = v.f1.addr;
    m1_byte_enable = v.f1.be; m1_write_data = v.f1.wd;
    fw = v.exp_grant ? v.f1 : v.f0;
    @(posedge clk); @(negedge clk);
    check("bus_enable_start", io_bus_enable, 1);
    check("grant_id", grant_id, v.exp_grant);
    check("busy_issue", busy, 1);
    check("io_rw", io_rw, fw.rw);
    check("io_address", io_address, fw.addr);
    check("io_byte_enable", io_byte_enable, fw.be);
    check("io_write_data", io_write_data, fw.wd);
    n = 0;
    while (io_bus_enable && n < T + 2) begin
      n++;
      io_acknowledge = (n == v.ack_at);
      io_read_data   = (n == v.ack_at) ? v.dev : 16'($urandom);
      @(posedge clk); @(negedge clk);
      io_acknowledge = 1'b0;
    end
    check("issue_cycles", n, v.exp_cycles);
    check("m0_done", m0_done, !v.exp_grant);
    check("m1_done", m1_done, v.exp_grant);
    check("owner_timeout", v.exp_grant ? m1_timeout : m0_timeout, v.exp_to);
    shadow[v.exp_grant] = v.exp_rd;
    check("m0_read_data", m0_read_data, shadow[0]);
    check("m1_read_data", m1_read_data, shadow[1]);
    check("busy_complete", busy, 1);
    last_owner = v.exp_grant;
    if (!v.keep) begin
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    check("done_single_pulse", {m0_done, m1_done}, 2'b00);
    check("busy_idle", busy, 0);
    check("bus_enable_idle", io_bus_enable, 0);
    check("io_address_hold", io_address, fw.addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_rw = 0; m0_address = 0; m0_byte_enable = 0; m0_write_data = 0;
    m1_rw = 0; m1_address = 0; m1_byte_enable = 0; m1_write_data = 0;
    io_read_data = 0;
    reset = 1'b1;
    m0_req = 0; m1_req = 0; io_acknowledge = 0; io_irq = 0;
    @(negedge clk);
    check("rst_bus_enable", io_bus_enable, 0);
    check("rst_io_rw", io_rw, 1);
    check("rst_io_address", io_address, 0);
    check("rst_io_byte_enable", io_byte_enable, 0);
    check("rst_io_write_data", io_write_data, 0);
    check("rst_done", {m0_done, m1_done, m0_timeout, m1_timeout}, 0);
    check("rst_read_data", {m0_read_data, m1_read_data}, 0);
    check("rst_busy_grant_irq", {busy, grant_id, irq_sync}, 0);
    apply_reset();

    tbl[0]  = mk(1, 1, '{1'b1, 16'h0100, 2'b11, 16'h0}, '{1'b1, 16'h0200, 2'b11, 16'h0}, 1, 16'hA001, 1, 0, 0, 16'hA001, 1);
    tbl[1]  = mk(1, 1, '{1'b1, 16'h0100, 2'b11, 16'h0}, '{1'b1, 16'h0200, 2'b11, 16'h0}, 1, 16'hA002, 1, 1, 0, 16'hA002, 1);
    tbl[2]  = mk(1, 1, '{1'b1, 16'h0100, 2'b11, 16'h0}, '{1'b1, 16'h0200, 2'b11, 16'h0}, 2, 16'hA003, 1, 0, 0, 16'hA003, 2);
    tbl[3]  = mk(1, 1, '{1'b1, 16'h0100, 2'b11, 16'h0}, '{1'b1, 16'h0200, 2'b11, 16'h0}, 1, 16'hA004, 0, 1, 0, 16'hA004, 1);
    tbl[4]  = mk(1, 0, '{1'b1, 16'h0040, 2'b11, 16'h0}, '{1'b0, 16'h0, 2'b00, 16'h0}, 3, 16'hBEEF, 0, 0, 0, 16'hBEEF, 3);
    tbl[5]  = mk(0, 1, '{1'b1, 16'h0, 2'b00, 16'h0}, '{1'b0, 16'h0010, 2'b01, 16'h1234}, 2, 16'h5555, 0, 1, 0, 16'hA004, 2);
    tbl[6]  = mk(1, 0, '{1'b1, 16'h0080, 2'b11, 16'h0}, '{1'b0, 16'h0, 2'b00, 16'h0}, 0, 16'h0000, 0, 0, 1, 16'hFFFF, T);
    tbl[7]  = mk(1, 0, '{1'b1, 16'h0084, 2'b10, 16'h0}, '{1'b0, 16'h0, 2'b00, 16'h0}, T, 16'h0A0A, 0, 0, 0, 16'h0A0A, T);
    tbl[8]  = mk(0, 1, '{1'b1, 16'h0, 2'b00, 16'h0}, '{1'b0, 16'h0020, 2'b10, 16'hCAFE}, 0, 16'h0000, 0, 1, 1, 16'hA004, T);
    tbl[9]  = mk(1, 1, '{1'b0, 16'h0030, 2'b11, 16'h1111}, '{1'b1, 16'h0034, 2'b11, 16'h0}, 1, 16'h9999, 0, 0, 0, 16'h0A0A, 1);
    tbl[10] = mk(1, 1, '{1'b0, 16'h0030, 2'b11, 16'h1111}, '{1'b1, 16'h0034, 2'b11, 16'h0}, 1, 16'h7777, 0, 1, 0, 16'h7777, 1);
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i]);
    end

    // Acknowledge while idle must not start or complete anything.
    io_acknowledge = 1'b1;
    io_read_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("idle_ack_busy", busy, 0);
      check("idle_ack_done", {m0_done, m1_done}, 2'b00);
    end
    io_acknowledge = 1'b0;
    check("idle_ack_rdata", {m0_read_data, m1_read_data}, {shadow[0], shadow[1]});

    // Reset in the second ISSUE cycle.
    m0_req = 1'b1; m0_rw = 1'b1; m0_address = 16'h0EE0; m0_byte_enable = 2'b11;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("pre_reset_bus_enable", io_bus_enable, 1);
    reset = 1'b1;
    #1;
    check("async_rst_bus_enable", io_bus_enable, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_io_rw", io_rw, 1);
    check("async_rst_io_address", io_address, 0);
    check("async_rst_read_data", {m0_read_data, m1_read_data}, 0);
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_owner = 1;
    shadow[0] = 16'h0;
    shadow[1] = 16'h0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      seen_done = seen_done | m0_done | m1_done;
    end
    check("no_done_after_abort", seen_done, 0);
    run_txn(mk(0, 1, '{1'b1, 16'h0, 2'b00, 16'h0}, '{1'b1, 16'h0600, 2'b11, 16'h0}, 2, 16'h4242, 0, 1, 0, 16'h4242, 2));

    // io_irq pulse of four cycles.
    io_irq = 1'b1;
    first_hi = -1;
    hi_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (irq_sync) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
      if (i == 4) io_irq = 1'b0;
    end
    check("irq_latency_2_to_3", (first_hi >= 2 && first_hi <= 3), 1);
    check("irq_width", hi_cnt, 4);

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 30; i++) begin
      pick = 2'($urandom_range(1, 3));
      rv.r0 = pick[0];
      rv.r1 = pick[1];
      rf.rw = 1'($urandom_range(0, 1)); rf.addr = 16'($urandom);
      rf.be = 2'($urandom); rf.wd = 16'($urandom);
      rv.f0 = rf;
      rf.rw = 1'($urandom_range(0, 1)); rf.addr = 16'($urandom);
      rf.be = 2'($urandom); rf.wd = 16'($urandom);
      rv.f1 = rf;
      rv.ack_at = $urandom_range(0, T + 2);
      rv.dev = 16'($urandom);
      rv.keep = 1'b0;
      if (rv.r0 && rv.r1) rv.exp_grant = (last_owner == 0);
      else                rv.exp_grant = rv.r1;
      acked = (rv.ack_at >= 1) && (rv.ack_at <= T);
      rv.exp_cycles = acked ? rv.ack_at : T;
      rv.exp_to = !acked;
      rf = rv.exp_grant ? rv.f1 : rv.f0;
      if (rf.rw) rv.exp_rd = acked ? rv.dev : 16'hFFFF;
      else       rv.exp_rd = shadow[rv.exp_grant];
      run_txn(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
